ahb_uart_bridge_mc: RTL and testbench

AHB_UART_BRIDGE_MC -- requirements
Module: ahb_uart_bridge_mc

---
 rtl/ahb_bridge_pkg.sv | 26 ++
 rtl/bridge_cmd_fifo.sv | 55 +++++
 rtl/ahb_uart_bridge_mc.sv | 162 ++++++++++++++++
 tb/tb_ahb_uart_bridge_mc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared constants for the UART-to-AHB command bridge: FSM encoding and frame layout.
// Frame layout from LSB: write, addr, data, sel, valid.
package ahb_bridge_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StXfer = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam int unsigned WriteOff = 0;
  localparam int unsigned AddrOff  = 1;

  function automatic int unsigned frame_w(input int unsigned sel_w, input int unsigned udata_w,
                                          input int unsigned uaddr_w);
    return 2 + sel_w + udata_w + uaddr_w;
  endfunction

  function automatic int unsigned data_off(input int unsigned uaddr_w);
    return AddrOff + uaddr_w;
  endfunction

  function automatic int unsigned sel_off(input int unsigned uaddr_w, input int unsigned udata_w);
    return data_off(uaddr_w) + udata_w;
  endfunction

endpackage

// File: rtl/bridge_cmd_fifo.sv
// Show-ahead command FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module bridge_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still legal.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ahb_uart_bridge_mc.sv
// Bridges UART command frames onto an AHB master interface, one transaction at a time,
// returning a response frame per command (with err set when grant or ready times out).
module ahb_uart_bridge_mc
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned UDATA_W    = 8,
  parameter int unsigned UADDR_W    = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned FRAME_W   = frame_w(SEL_W, UDATA_W, UADDR_W)
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic [FRAME_W-1:0] rx_frame,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               hgrant,
  output logic               m_req,
  output logic [31:0]        m_addr,
  output logic [31:0]        m_wdata,
  output logic               m_write,
  output logic [SEL_W-1:0]   m_sel,
  input  logic               m_hready,
  input  logic [31:0]        hrdata,
  output logic [FRAME_W-1:0] tx_frame,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               ovf
);

  localparam int unsigned PL_W    = FRAME_W - 1;
  localparam int unsigned DataOff = data_off(UADDR_W);
  localparam int unsigned SelOff  = sel_off(UADDR_W, UDATA_W);
  localparam int unsigned CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               m_write_q, m_write_d;
  logic [UADDR_W-1:0] m_addr_q, m_addr_d;
  logic [UDATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [SEL_W-1:0]   m_sel_q, m_sel_d;
  logic [FRAME_W-1:0] tx_frame_q, tx_frame_d;
  logic               ovf_q, ovf_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PL_W-1:0]    fifo_rdata;
  logic               frame_valid;
  logic               hrdata_unused;

  assign hrdata_unused = ^hrdata[31:UDATA_W];

  assign frame_valid = rx_valid & rx_frame[FRAME_W-1];
  assign rx_ready    = ~fifo_full;
  assign fifo_push   = frame_valid & rx_ready;
  assign ovf_d       = ovf_q | (frame_valid & ~rx_ready);

  bridge_cmd_fifo #(
    .WIDTH (PL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .hclk   (hclk),
    .hreset (hreset),
    .push   (fifo_push),
    .wdata  (rx_frame[PL_W-1:0]),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    fifo_pop   = 1'b0;
    m_write_d  = m_write_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_sel_d    = m_sel_q;
    tx_frame_d = tx_frame_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_d   = StReq;
          wait_d    = '0;
          m_write_d = fifo_rdata[WriteOff];
          m_addr_d  = fifo_rdata[AddrOff +: UADDR_W];
          m_wdata_d = fifo_rdata[DataOff +: UDATA_W];
          m_sel_d   = fifo_rdata[SelOff +: SEL_W];
        end
      end
      StReq: begin
        if (hgrant) begin
          state_d = StXfer;
          wait_d  = '0;
        end else if (wait_q == TimeoutVal) begin
          state_d    = StResp;
          wait_d     = '0;
          tx_frame_d = {1'b1, m_sel_q, {UDATA_W{1'b0}}, m_addr_q, 1'b1};
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StXfer: begin
        if (m_hready) begin
          state_d    = StResp;
          wait_d     = '0;
          tx_frame_d = {1'b1, m_sel_q, (m_write_q ? m_wdata_q : hrdata[UDATA_W-1:0]),
                        m_addr_q, 1'b0};
        end else if (wait_q == TimeoutVal) begin
          state_d    = StResp;
          wait_d     = '0;
          tx_frame_d = {1'b1, m_sel_q, {UDATA_W{1'b0}}, m_addr_q, 1'b1};
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StResp: begin
        if (tx_ready) begin
          state_d    = StIdle;
          wait_d     = '0;
          tx_frame_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      m_write_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_sel_q    <= '0;
      tx_frame_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      m_write_q  <= m_write_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_sel_q    <= m_sel_d;
      tx_frame_q <= tx_frame_d;
      ovf_q      <= ovf_d;
    end
  end

  assign m_req    = (state_q == StReq) | (state_q == StXfer);
  assign tx_valid = (state_q == StResp);
  assign tx_frame = tx_frame_q;
  assign m_write  = m_write_q;
  assign m_addr   = 32'(m_addr_q);
  assign m_wdata  = 32'(m_wdata_q);
  assign m_sel    = m_sel_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_ahb_uart_bridge_mc.sv
// Directed bench for ahb_uart_bridge_mc at default parameters (17-bit frames, depth 4).
module tb_ahb_uart_bridge_mc;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [16:0] rx_frame;
  logic        rx_valid;
  logic        rx_ready;
  logic        hgrant;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_write;
  logic [1:0]  m_sel;
  logic        m_hready;
  logic [31:0] hrdata;
  logic [16:0] tx_frame;
  logic        tx_valid;
  logic        tx_ready;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  ahb_uart_bridge_mc dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .rx_frame (rx_frame),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .hgrant   (hgrant),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_write  (m_write),
    .m_sel    (m_sel),
    .m_hready (m_hready),
    .hrdata   (hrdata),
    .tx_frame (tx_frame),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ovf      (ovf)
  );

  always #5 hclk = ~hclk;

  function automatic logic [16:0] rxf(input logic [1:0] sel, input logic [7:0] d,
                                      input logic [4:0] a, input logic w);
    return {1'b1, sel, d, a, w};
  endfunction

  function automatic logic [16:0] txf(input logic [1:0] sel, input logic [7:0] d,
                                      input logic [4:0] a, input logic err);
    return {1'b1, sel, d, a, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic [16:0] f);
    rx_frame = f;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic accept();
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] held;
    int seen;
    hreset = 1'b1; rx_frame = '0; rx_valid = 1'b0; hgrant = 1'b0; m_hready = 1'b0;
    hrdata = '0; tx_ready = 1'b0;
    tick(2);
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_frame", 32'(tx_frame), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_m_addr", m_addr, 0);
    hreset = 1'b0;
    tick(1);

    // Write with grant/ready already high: response in the 4th cycle after the push.
    hgrant = 1'b1; m_hready = 1'b1;
    push(rxf(2'd2, 8'hA5, 5'h03, 1'b1));
    tick(1);
    chk("wr_m_addr", m_addr, 32'h3);
    chk("wr_m_wdata", m_wdata, 32'hA5);
    chk("wr_m_sel", 32'(m_sel), 2);
    chk("wr_m_write", 32'(m_write), 1);
    chk("wr_m_req", 32'(m_req), 1);
    tick(1);
    chk("wr_tx_valid_early", 32'(tx_valid), 0);
    tick(1);
    chk("wr_tx_valid", 32'(tx_valid), 1);
    chk("wr_tx_frame", 32'(tx_frame), 32'(txf(2'd2, 8'hA5, 5'h03, 1'b0)));
    chk("wr_resp_m_req", 32'(m_req), 0);
    accept();
    chk("wr_done", 32'(tx_valid), 0);

    // Read returns the low data byte of hrdata.
    hrdata = 32'h1234_5678;
    push(rxf(2'd1, 8'h00, 5'h1F, 1'b0));
    wait_tx("rd_wait", 10);
    chk("rd_tx_frame", 32'(tx_frame), 32'(txf(2'd1, 8'h78, 5'h1F, 1'b0)));
    chk("rd_m_write", 32'(m_write), 0);
    chk("rd_m_addr", m_addr, 32'h1F);
    accept();

    // Backpressure: frame held, no new request while a second command waits.
    push(rxf(2'd0, 8'h3C, 5'h05, 1'b1));
    push(rxf(2'd3, 8'h5A, 5'h06, 1'b1));
    wait_tx("bp_wait", 10);
    held = tx_frame;
    chk("bp_first", 32'(held), 32'(txf(2'd0, 8'h3C, 5'h05, 1'b0)));
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_stable", 32'(tx_frame), 32'(txf(2'd0, 8'h3C, 5'h05, 1'b0)));
      chk("bp_no_req", 32'(m_req), 0);
      chk("bp_valid", 32'(tx_valid), 1);
    end
    accept();
    wait_tx("bp_wait2", 10);
    chk("bp_second", 32'(tx_frame), 32'(txf(2'd3, 8'h5A, 5'h06, 1'b0)));
    accept();

    // Grant timeout: REQ lasts 256 cycles, then an error response with data 0.
    hgrant = 1'b0;
    push(rxf(2'd1, 8'h11, 5'h02, 1'b1));
    push(rxf(2'd2, 8'h22, 5'h04, 1'b1));
    tick(255);
    chk("to_not_yet", 32'(tx_valid), 0);
    chk("to_req_held", 32'(m_req), 1);
    tick(1);
    chk("to_valid", 32'(tx_valid), 1);
    chk("to_frame", 32'(tx_frame), 32'(txf(2'd1, 8'h00, 5'h02, 1'b1)));
    hgrant = 1'b1;
    accept();
    wait_tx("to_next_wait", 10);
    chk("to_next_frame", 32'(tx_frame), 32'(txf(2'd2, 8'h22, 5'h04, 1'b0)));
    accept();

    // Overflow: six back-to-back pushes with the transmitter stalled.
    for (int i = 0; i < 6; i++) begin
      rx_frame = rxf(2'(i), 8'h40 + 8'(i), 5'(i), 1'b1);
      rx_valid = 1'b1;
      tick(1);
    end
    rx_valid = 1'b0;
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_full", 32'(rx_ready), 0);
    for (int k = 0; k < 5; k++) begin
      wait_tx("ovf_wait", 20);
      chk("ovf_order", 32'(tx_frame), 32'(txf(2'(k), 8'h40 + 8'(k), 5'(k), 1'b0)));
      accept();
    end
    tick(10);
    chk("ovf_dropped", 32'(tx_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);

    // Reset in XFER, with a concurrent push, discards everything.
    m_hready = 1'b0; tx_ready = 1'b1;
    push(rxf(2'd3, 8'h77, 5'h1A, 1'b1));
    tick(2);
    chk("xr_in_xfer", 32'(m_req), 1);
    chk("xr_sel", 32'(m_sel), 3);
    hreset = 1'b1;
    rx_frame = rxf(2'd1, 8'h99, 5'h09, 1'b1);
    rx_valid = 1'b1;
    tick(1);
    hreset = 1'b0; rx_valid = 1'b0; m_hready = 1'b1;
    chk("xr_m_req", 32'(m_req), 0);
    chk("xr_m_addr", m_addr, 0);
    chk("xr_m_wdata", m_wdata, 0);
    chk("xr_m_sel", 32'(m_sel), 0);
    chk("xr_m_write", 32'(m_write), 0);
    chk("xr_tx_valid", 32'(tx_valid), 0);
    chk("xr_tx_frame", 32'(tx_frame), 0);
    chk("xr_ovf", 32'(ovf), 0);
    chk("xr_rx_ready", 32'(rx_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen += int'(tx_valid) + int'(m_req);
    end
    chk("xr_quiet", 32'(seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
